// File: rtl/debounce_bank.sv
// Multi-channel debounce filter: per-channel consecutive-sample counter, clean levels and one-cycle rise/fall strobes.
// Optional two-flop input synchroniser enabled by defining DEBOUNCE_BANK_SYNC_EN.
module debounce_bank #(
    parameter int                      NUM_CHANNELS   = 4,
    parameter int                      DEBOUNCE_LIMIT = 20,
    parameter logic [NUM_CHANNELS-1:0] INIT_STATE     = {NUM_CHANNELS{1'b0}}
) (
    input  logic                    i_Clk,
    input  logic                    i_Rst_L,
    input  logic [NUM_CHANNELS-1:0] i_Bouncy,
    output logic [NUM_CHANNELS-1:0] o_Debounced,
    output logic [NUM_CHANNELS-1:0] o_Rise,
    output logic [NUM_CHANNELS-1:0] o_Fall,
    output logic                    o_Any_Change
);

    localparam int            CW    = $clog2(DEBOUNCE_LIMIT);
    localparam logic [CW-1:0] C_MAX = CW'(DEBOUNCE_LIMIT - 1);

    logic [NUM_CHANNELS-1:0] w_sample;
    logic [NUM_CHANNELS-1:0] w_accept;
    logic [NUM_CHANNELS-1:0] r_state;
    logic [NUM_CHANNELS-1:0] r_rise;
    logic [NUM_CHANNELS-1:0] r_fall;
    logic                    r_any;
    logic [CW-1:0]           r_count [NUM_CHANNELS];

`ifdef DEBOUNCE_BANK_SYNC_EN
    logic [NUM_CHANNELS-1:0] r_sync1;
    logic [NUM_CHANNELS-1:0] r_sync2;

    // Synchroniser resets to the idle level so reset release never looks like an input edge.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_sync1 <= INIT_STATE;
            r_sync2 <= INIT_STATE;
        end else begin
            r_sync1 <= i_Bouncy;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = i_Bouncy;
`endif

    always_comb begin
        w_accept = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            w_accept[i] = (w_sample[i] != r_state[i]) && (r_count[i] == C_MAX);
        end
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_state <= INIT_STATE;
            r_rise  <= '0;
            r_fall  <= '0;
            r_any   <= 1'b0;
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                r_count[i] <= '0;
            end
        end else begin
            r_state <= (r_state & ~w_accept) | (w_sample & w_accept);
            r_rise  <= w_accept & w_sample;
            r_fall  <= w_accept & ~w_sample;
            r_any   <= |w_accept;
            // Any matching sample restarts the count, so acceptance needs strictly consecutive samples.
            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if ((w_sample[i] == r_state[i]) || w_accept[i]) begin
                    r_count[i] <= '0;
                end else begin
                    r_count[i] <= r_count[i] + 1'b1;
                end
            end
        end
    end

    assign o_Debounced  = r_state;
    assign o_Rise       = r_rise;
    assign o_Fall       = r_fall;
    assign o_Any_Change = r_any;

endmodule

// File: tb/tb_debounce_bank.sv
// Bench for debounce_bank: reset, table of per-cycle vectors, then latency and mid-count reset sequences.
module tb_debounce_bank;

`ifdef DEBOUNCE_BANK_SYNC_EN
    localparam int SYNC_DLY = 2;
`else
    localparam int SYNC_DLY = 0;
`endif
    localparam int LIMIT = 4;
    localparam int LAT   = LIMIT + SYNC_DLY;
    localparam int NVEC  = 32;

    typedef struct {
        logic [3:0] bouncy;
        logic [3:0] deb;
        logic [3:0] rise;
        logic [3:0] fall;
        logic       any;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic [3:0] bouncy;
    logic [3:0] deb;
    logic [3:0] rise;
    logic [3:0] fall;
    logic       any_chg;

    vec_t        vecs [NVEC];
    logic [12:0] exp_q [$];
    int          n_cmp;
    int          n_err;

    debounce_bank #(
        .NUM_CHANNELS  (4),
        .DEBOUNCE_LIMIT(LIMIT),
        .INIT_STATE    (4'b0101)
    ) dut (
        .i_Clk       (clk),
        .i_Rst_L     (rst_n),
        .i_Bouncy    (bouncy),
        .o_Debounced (deb),
        .o_Rise      (rise),
        .o_Fall      (fall),
        .o_Any_Change(any_chg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string name, input logic [3:0] e_deb, input logic [3:0] e_rise,
                             input logic [3:0] e_fall, input logic e_any);
        check({name, ".deb"},  deb,  e_deb);
        check({name, ".rise"}, rise, e_rise);
        check({name, ".fall"}, fall, e_fall);
        check({name, ".any"},  {3'b000, any_chg}, {3'b000, e_any});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until o_Debounced leaves prev; gives up after 40 edges.
    task automatic wait_change(input logic [3:0] prev, output int edges);
        edges = 0;
        while (edges < 40) begin
            tick();
            edges++;
            if (deb !== prev) break;
        end
    endtask

    task automatic set_vec(input int idx, input logic [3:0] b, input logic [3:0] d,
                           input logic [3:0] r, input logic [3:0] f, input logic a);
        vecs[idx].bouncy = b;
        vecs[idx].deb    = d;
        vecs[idx].rise   = r;
        vecs[idx].fall   = f;
        vecs[idx].any    = a;
    endtask

    initial begin
        int          edges;
        logic [12:0] e;

        n_cmp = 0;
        n_err = 0;

        // Expected values are for a direct-sampling filter; the synchroniser only delays them.
        set_vec(0,  4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(1,  4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(2,  4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(3,  4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(4,  4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(5,  4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(6,  4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(7,  4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(8,  4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(9,  4'b0101, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(10, 4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(11, 4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(12, 4'b0111, 4'b0101, 4'b0000, 4'b0000, 1'b0);
        set_vec(13, 4'b0111, 4'b0111, 4'b0010, 4'b0000, 1'b1);
        set_vec(14, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(15, 4'b0011, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(16, 4'b0011, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(17, 4'b0011, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(18, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(19, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(20, 4'b1110, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(21, 4'b1110, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(22, 4'b1110, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(23, 4'b1110, 4'b1110, 4'b1000, 4'b0001, 1'b1);
        set_vec(24, 4'b1110, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        set_vec(25, 4'b0111, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        set_vec(26, 4'b0111, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        set_vec(27, 4'b0111, 4'b1110, 4'b0000, 4'b0000, 1'b0);
        set_vec(28, 4'b0111, 4'b0111, 4'b0001, 4'b1000, 1'b1);
        set_vec(29, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(30, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);
        set_vec(31, 4'b0111, 4'b0111, 4'b0000, 4'b0000, 1'b0);

        // Reset held for 3 cycles, then 20 quiet cycles.
        rst_n  = 1'b0;
        bouncy = 4'b0101;
        #2;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_all("reset_hold", 4'b0101, 4'b0000, 4'b0000, 1'b0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check_all("post_reset", 4'b0101, 4'b0000, 4'b0000, 1'b0);
        end

        // Bounce, short glitch and simultaneous rise/fall vectors.
        for (int i = 0; i < NVEC; i++) begin
            bouncy = vecs[i].bouncy;
            exp_q.push_back({vecs[i].deb, vecs[i].rise, vecs[i].fall, vecs[i].any});
            tick();
            if (exp_q.size() > SYNC_DLY) begin
                e = exp_q.pop_front();
                check_all($sformatf("vec%0d", i - SYNC_DLY), e[12:9], e[8:5], e[4:1], e[0]);
            end
        end

        // Clean rise on ch3: acceptance latency and one-cycle strobe.
        bouncy = 4'b1111;
        wait_change(4'b0111, edges);
        n_cmp++;
        if (edges != LAT) begin
            n_err++;
            $display("FAIL clean_latency: got %0d edges expected %0d", edges, LAT);
        end
        check_all("clean_accept", 4'b1111, 4'b1000, 4'b0000, 1'b1);
        tick();
        check_all("clean_after", 4'b1111, 4'b0000, 4'b0000, 1'b0);

        // Mid-count reset: ch0 counts to 2, reset, then a full count is needed again.
        bouncy = 4'b1110;
        repeat (SYNC_DLY + 2) tick();
        check_all("midcount_pre", 4'b1111, 4'b0000, 4'b0000, 1'b0);
        rst_n = 1'b0;
        #2;
        check_all("midcount_rst", 4'b0101, 4'b0000, 4'b0000, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        wait_change(4'b0101, edges);
        n_cmp++;
        if (edges != LAT) begin
            n_err++;
            $display("FAIL midcount_latency: got %0d edges expected %0d", edges, LAT);
        end
        check_all("midcount_accept", 4'b1110, 4'b1010, 4'b0001, 1'b1);
        tick();
        check_all("midcount_after", 4'b1110, 4'b0000, 4'b0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Multi-channel debounce filter: N independent bouncy inputs (buttons, switches, mechanical contacts) are each optionally synchronised, filtered by a per-channel consecutive-sample counter, and presented as clean levels plus single-cycle rise/fall strobes. It sits directly behind the board I/O pins and feeds UI/control logic. It generalises the single-channel debounce filter with channel count, reset level, edge strobes and an input synchroniser.

## Interface

- NUM_CHANNELS, 4: number of independent channels (>=1).
- DEBOUNCE_LIMIT, 20: consecutive differing samples required to accept a new level (>=2).
- INIT_STATE, {NUM_CHANNELS{1'b0}}: per-channel level loaded at reset (width NUM_CHANNELS).
- i_Clk  input  1  system clock; all logic on rising edge.
- i_Rst_L  input  1  reset, asynchronous assert, active-low; deassertion assumed synchronous to i_Clk upstream.
- i_Bouncy  input  NUM_CHANNELS  raw inputs, bit i = channel i.
- o_Debounced  output  NUM_CHANNELS  filtered level per channel.
- o_Rise  output  NUM_CHANNELS  one-cycle strobe, channel accepted 0->1.
- o_Fall  output  NUM_CHANNELS  one-cycle strobe, channel accepted 1->0.
- o_Any_Change  output  1  OR of all o_Rise and o_Fall bits (registered).

## Operation

- Per channel: sample s = synchroniser output (or raw i_Bouncy, see Configuration); registered state r; counter c, width $clog2(DEBOUNCE_LIMIT).
- Each clock, per channel:
  - s == r: c <= 0; no strobe.
  - s != r and c < DEBOUNCE_LIMIT-1: c <= c+1.
  - s != r and c == DEBOUNCE_LIMIT-1: r <= s; c <= 0; o_Rise or o_Fall asserted next cycle per direction.
- A single matching sample during counting clears c; count restarts from 0 (strictly consecutive).
- Counter never exceeds DEBOUNCE_LIMIT-1; no wrap.
- Channels fully independent; simultaneous acceptance on several channels asserts each strobe bit in the same cycle, o_Any_Change once.
- o_Rise/o_Fall/o_Any_Change are registered, high exactly one cycle per accepted transition; o_Rise[i] and o_Fall[i] never both high.
- Reset (i_Rst_L low, any time, including mid-count): r <= INIT_STATE, all c <= 0, synchroniser flops <= INIT_STATE, all strobes <= 0. No strobe generated on or after reset release unless a new level is subsequently accepted.
- o_Debounced = r.

## Timing

- Reset values: o_Debounced = INIT_STATE, o_Rise = 0, o_Fall = 0, o_Any_Change = 0.
- Raw input settled at new level before edge k and held:
  - sync compiled in: r and strobe update at edge k+DEBOUNCE_LIMIT+1 (DEBOUNCE_LIMIT+2 edges inclusive).
  - sync compiled out: r and strobe update at edge k+DEBOUNCE_LIMIT-1 (DEBOUNCE_LIMIT edges inclusive).
- Strobe visible in the cycle after that edge, same cycle o_Debounced first shows new level; deasserts on following edge.
- Pulse shorter than DEBOUNCE_LIMIT sample cycles: never accepted, no strobe.

## Configuration

- DEBOUNCE_BANK_SYNC_EN defined: two-flop synchroniser per channel ahead of the counter (reset to INIT_STATE); use for asynchronous pins.
- Not defined: counter samples i_Bouncy directly; inputs must already be synchronous to i_Clk; latency reduced by 2 cycles.

## Test plan

- Reset: NUM_CHANNELS=4, INIT_STATE=4'b0101, i_Bouncy=4'b0101, hold i_Rst_L low 3 cycles -> o_Debounced=4'b0101, all strobes 0 during and 20 cycles after release.
- Clean edge, DEBOUNCE_LIMIT=4, sync on: ch0 0->1 held -> o_Debounced[0]=1 and o_Rise[0] high exactly 1 cycle, 6 edges after change; off: 4 edges.
- Bounce: ch1 toggles 1,0,1,0 every 2 cycles then steady 1, LIMIT=4 -> single o_Rise[1] only after 4 consecutive high samples; no o_Fall.
- Short glitch: ch2 high for 3 cycles with LIMIT=4 -> o_Debounced[2] stays 0, no strobes.
- Simultaneous: ch0 rise and ch3 fall on same cycle -> o_Rise=4'b0001, o_Fall=4'b1000 same cycle, o_Any_Change high 1 cycle.
- Mid-count reset: ch0 differing, c=2, assert i_Rst_L low -> counter cleared; after release, full DEBOUNCE_LIMIT consecutive samples needed before acceptance.
